// File: rtl/regfile_writeback.sv
// Write-side front end for the 32x32 register file.
// Merges single-cycle ALU results with queued long-latency results onto one
// registered write port, and keeps a pending scoreboard for outstanding long writes.
module regfile_writeback #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic        iss_long,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  qry_addr1,
    input  logic [4:0]  qry_addr2,
    output logic        qry_busy1,
    output logic        qry_busy2,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lng_valid,
    output logic        lng_ready,
    input  logic [4:0]  lng_rd,
    input  logic [31:0] lng_data,
    output logic        we,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [31:0]      pending;
    logic [31:0]      pending_next;
    logic [4:0]       fifo_rd   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [AGE_W-1:0] age;

    logic fifo_nonempty;
    logic force_head;
    logic alu_take;
    logic pop;
    logic push;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign fifo_nonempty = (count != '0);
    // A head that has waited STARVE_LIMIT cycles locks the ALU out for one cycle.
    assign force_head    = fifo_nonempty && (age == AGE_W'(STARVE_LIMIT));
    assign alu_ready     = ~force_head;
    assign lng_ready     = (count != CNT_W'(DEPTH));
    assign alu_take      = alu_valid & ~force_head;
    assign pop           = ~alu_take & fifo_nonempty;
    assign push          = lng_valid & lng_ready;
    assign head_rd       = fifo_rd[rd_ptr];
    assign head_data     = fifo_data[rd_ptr];

    // Scoreboard lookups see only registered state, never this cycle's set/clear.
    assign qry_busy1 = pending[qry_addr1];
    assign qry_busy2 = pending[qry_addr2];

    // Pending bitmap next state: clear on long write-back, then set on issue (set wins).
    always_comb begin
        pending_next = pending;
        if (pop && (head_rd != 5'd0)) begin
            pending_next[head_rd] = 1'b0;
        end
        if (iss_valid && iss_long && (iss_rd != 5'd0)) begin
            pending_next[iss_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // FIFO storage; contents are don't-care while the slot is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lng_rd;
            fifo_data[wr_ptr] <= lng_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Head age: counts cycles the head is passed over, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else if (!fifo_nonempty || pop) begin
            age <= '0;
        end else if (age != AGE_W'(STARVE_LIMIT)) begin
            age <= age + AGE_W'(1);
        end
    end

    // Registered write port; rd=0 still takes the slot but does not write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we        <= 1'b0;
            WriteAddr <= 5'd0;
            WriteData <= 32'd0;
        end else if (alu_take) begin
            we        <= (alu_rd != 5'd0);
            WriteAddr <= alu_rd;
            WriteData <= alu_data;
        end else if (pop) begin
            we        <= (head_rd != 5'd0);
            WriteAddr <= head_rd;
            WriteData <= head_data;
        end else begin
            we        <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end for the 32x32 register file: the single producer of its write port (we, WriteAddr, WriteData).
- Merges single-cycle ALU results with results from long-latency units (load/mul/div) onto that one write port.
- Keeps a per-register pending scoreboard so the issue stage can stall on RAW/WAW hazards against outstanding long-latency writes.

Parameters:
DEPTH, 2, long-result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive cycles a FIFO head may be blocked by ALU traffic before it is forced through

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
iss_valid  input  1  instruction issued this cycle
iss_long  input  1  issued op is long-latency
iss_rd  input  5  destination of issued op
qry_addr1  input  5  scoreboard query address 1
qry_addr2  input  5  scoreboard query address 2
qry_busy1  output  1  qry_addr1 has a pending long write (combinational)
qry_busy2  output  1  qry_addr2 has a pending long write (combinational)
alu_valid  input  1  ALU result present
alu_ready  output  1  ALU result accepted this cycle (combinational)
alu_rd  input  5  ALU destination
alu_data  input  32  ALU result
lng_valid  input  1  long-unit result present
lng_ready  output  1  FIFO can accept (combinational)
lng_rd  input  5  long-unit destination
lng_data  input  32  long-unit result
we  output  1  register-file write enable (registered)
WriteAddr  output  5  register-file write address (registered)
WriteData  output  32  register-file write data (registered)

Behaviour:
- Reset (rst=1 at a clock edge): we=0, WriteAddr=0, WriteData=0, FIFO empty, pending bitmap=0, age counter=0. Reset asserted mid-operation discards all FIFO contents and pending bits.
- Scoreboard:
  - 32-bit pending bitmap; bit 0 is hard-wired 0.
  - Set on iss_valid & iss_long & iss_rd!=0.
  - Cleared when a FIFO entry for that rd drives the write port.
  - Set and clear of the same bit in the same cycle: set wins.
  - qry_busyN = pending[qry_addrN]; no bypass of same-cycle set or clear.
- FIFO:
  - Push when lng_valid & lng_ready; lng_ready = (count != DEPTH).
  - No push when full, even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
- Write-port arbitration, evaluated each cycle:
  - force = (count != 0) & (age == STARVE_LIMIT).
  - alu_ready = ~force.
  - If alu_valid & alu_ready: next port = {1, alu_rd, alu_data}.
  - Else if count != 0: pop head; next port = {1, head.rd, head.data}; age resets to 0.
  - Else: next we=0; WriteAddr and WriteData hold their previous values.
- Age counter:
  - Increments when count != 0 and the head is not popped.
  - Resets to 0 on pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Any source with rd=0 still occupies the write port but drives we=0.
- Latency:
  - ALU: accept at edge N, we=1 during cycle N+1.
  - Long unit: accept at edge N, earliest we=1 during cycle N+2 (no FIFO bypass).
- Ordering: long results are written in FIFO (arrival) order. ALU and long results carry no mutual ordering; the issue stage must stall on qry_busy to prevent WAW.
- we is high for exactly one cycle per accepted result. At most one write per cycle.

Test Plan:
1. Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> next cycle we=1, WriteAddr=5, WriteData=0xDEADBEEF; following cycle we=0.
2. iss_valid=1, iss_long=1, iss_rd=7; qry_addr1=7 -> qry_busy1=0 that cycle, 1 from the next cycle. Push lng_rd=7, lng_data=0x12 -> we=1/WriteAddr=7 two cycles after accept; qry_busy1=0 the cycle after the write.
3. Fill FIFO with rd=1 and rd=2 while alu_valid held high (STARVE_LIMIT=4) -> lng_ready=0. Age reaches 4, then alu_ready=0 for one cycle and the rd=1 entry is written. lng_ready=1 the next cycle.
4. Long result, ALU result and issue all target rd=0 -> we stays 0 throughout; qry_busy for address 0 always 0.
5. Same cycle: long entry for rd=9 pops while iss_long issues rd=9 -> pending[9] remains 1.
6. Assert rst with FIFO holding 2 entries and pending bits set -> next cycle we=0, lng_ready=1, all qry_busy=0; no stale writes afterwards.
